// File: rtl/key_code_encoder.sv
// rtl/key_code_encoder.sv - ASCII byte to timed 4-bit key code pulses with gap and one-entry pending slot
module key_code_encoder #(
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ovr_clr,
  output logic [3:0] keyboard,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

  // Counter reload values: a pulse or gap of N cycles counts N-1 down to 0.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state, stateNext;
  logic [7:0] cnt, cntNext;
  logic [3:0] keyNext;
  logic [3:0] pendCode, pendCodeNext;
  logic       pendFull, pendFullNext;
  logic       overrunNext;
  logic       busyNext;
  logic [7:0] folded;
  logic [3:0] rxCode;
  logic       rxMapped;

  // Fold upper case to lower case and translate the byte into a key code.
  always_comb begin
    folded = rx_data;
    if (rx_data >= 8'h41 && rx_data <= 8'h5A) begin
      folded = rx_data | 8'h20;
    end
    case (folded)
      8'h20, 8'h0D: rxCode = 4'b1000;
      8'h77:        rxCode = 4'b0001;
      8'h73:        rxCode = 4'b0010;
      8'h61:        rxCode = 4'b0011;
      8'h64:        rxCode = 4'b0100;
      default:      rxCode = 4'b0000;
    endcase
    rxMapped = rx_valid && (rxCode != 4'b0000);
  end

  // Next-state, pulse timing, pending slot and overrun bookkeeping.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    keyNext      = keyboard;
    pendCodeNext = pendCode;
    pendFullNext = pendFull;
    overrunNext  = overrun & ~ovr_clr;
    case (state)
      IDLE: begin
        keyNext = 4'b0000;
        if (pendFull) begin
          // Slot drains first; a byte arriving now refills the freed slot.
          keyNext      = pendCode;
          cntNext      = PULSE_LOAD;
          stateNext    = EMIT;
          pendFullNext = rxMapped;
          if (rxMapped) begin
            pendCodeNext = rxCode;
          end
        end else if (rxMapped) begin
          keyNext   = rxCode;
          cntNext   = PULSE_LOAD;
          stateNext = EMIT;
        end
      end
      EMIT: begin
        if (cnt == 8'd0) begin
          keyNext   = 4'b0000;
          cntNext   = GAP_LOAD;
          stateNext = GAP;
        end else begin
          cntNext = cnt - 8'd1;
        end
        if (rxMapped) begin
          // Newest code wins; losing an unsent code is flagged.
          if (pendFull) begin
            overrunNext = 1'b1;
          end
          pendCodeNext = rxCode;
          pendFullNext = 1'b1;
        end
      end
      GAP: begin
        keyNext = 4'b0000;
        if (cnt == 8'd0 && pendFull) begin
          keyNext      = pendCode;
          cntNext      = PULSE_LOAD;
          stateNext    = EMIT;
          pendFullNext = rxMapped;
          if (rxMapped) begin
            pendCodeNext = rxCode;
          end
        end else begin
          if (cnt == 8'd0) begin
            stateNext = IDLE;
          end else begin
            cntNext = cnt - 8'd1;
          end
          if (rxMapped) begin
            if (pendFull) begin
              overrunNext = 1'b1;
            end
            pendCodeNext = rxCode;
            pendFullNext = 1'b1;
          end
        end
      end
      default: begin
        keyNext   = 4'b0000;
        stateNext = IDLE;
      end
    endcase
    busyNext = (stateNext != IDLE);
  end

  // State register with synchronous active-low reset; reset aborts any pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      keyboard <= 4'b0000;
      pendCode <= 4'b0000;
      pendFull <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      keyboard <= keyNext;
      pendCode <= pendCodeNext;
      pendFull <= pendFullNext;
      overrun  <= overrunNext;
      busy     <= busyNext;
    end
  end

endmodule

// File: tb/tb_key_code_encoder.sv
// tb/tb_key_code_encoder.sv - randomized and directed self-checking bench for key_code_encoder
module tb_key_code_encoder;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       ovrClr = 1'b0;
  logic [3:0] kbA, kbB;
  logic       busyA, busyB, ovrA, ovrB;

  int PULSES[2] = '{1, 4};
  int GAPS[2]   = '{1, 3};

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state, one entry per instance.
  int         pulseLeft[2];
  int         gapLeft[2];
  bit         pendFull[2];
  logic [3:0] pendCode[2];
  logic [3:0] cur[2];
  bit         ovr[2];

  logic [7:0] pool[13];

  key_code_encoder #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dutA (
    .clk(clk), .rst_n(rstN), .rx_data(rxData), .rx_valid(rxValid), .ovr_clr(ovrClr),
    .keyboard(kbA), .busy(busyA), .overrun(ovrA)
  );

  key_code_encoder #(.PULSE_CYCLES(4), .GAP_CYCLES(3)) dutB (
    .clk(clk), .rst_n(rstN), .rx_data(rxData), .rx_valid(rxValid), .ovr_clr(ovrClr),
    .keyboard(kbB), .busy(busyB), .overrun(ovrB)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] mapKey(input logic [7:0] b);
    string      keys;
    logic [7:0] c;
    keys = "wsad";
    c = b;
    if (c >= "A" && c <= "Z") c = c + 8'd32;
    if (c == " " || c == 8'h0d) return 4'b1000;
    for (int i = 0; i < 4; i++) begin
      if (c == keys[i]) return 4'(i + 1);
    end
    return 4'b0000;
  endfunction

  // Advance the model by one clock using the inputs presented on that edge.
  task automatic modelStep();
    logic [3:0] code;
    bit         mapped;
    bit         ovSet;
    code   = mapKey(rxData);
    mapped = rxValid && (code != 4'b0000);
    for (int i = 0; i < 2; i++) begin
      ovSet = 1'b0;
      if (!rstN) begin
        pulseLeft[i] = 0; gapLeft[i] = 0; pendFull[i] = 1'b0; cur[i] = 4'b0; ovr[i] = 1'b0;
      end else begin
        if (pulseLeft[i] > 0) begin
          pulseLeft[i]--;
          if (pulseLeft[i] == 0) gapLeft[i] = GAPS[i];
          if (mapped) begin ovSet = pendFull[i]; pendFull[i] = 1'b1; pendCode[i] = code; end
        end else if (gapLeft[i] > 0) begin
          gapLeft[i]--;
          if (gapLeft[i] == 0 && pendFull[i]) begin
            cur[i] = pendCode[i]; pulseLeft[i] = PULSES[i];
            pendFull[i] = mapped; pendCode[i] = code;
          end else if (mapped) begin
            ovSet = pendFull[i]; pendFull[i] = 1'b1; pendCode[i] = code;
          end
        end else if (pendFull[i]) begin
          cur[i] = pendCode[i]; pulseLeft[i] = PULSES[i];
          pendFull[i] = mapped; pendCode[i] = code;
        end else if (mapped) begin
          cur[i] = code; pulseLeft[i] = PULSES[i];
        end
        ovr[i] = ovSet ? 1'b1 : (ovrClr ? 1'b0 : ovr[i]);
      end
    end
  endtask

  // Present inputs for one clock, step the model, and compare away from the edge.
  task automatic cycle(input bit rv, input logic [7:0] rd, input bit clr, input bit rst);
    rxValid = rv; rxData = rd; ovrClr = clr; rstN = rst;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkVal("A.kb",   8'(kbA),   8'(pulseLeft[0] > 0 ? cur[0] : 4'b0));
    checkVal("A.busy", 8'(busyA), 8'(pulseLeft[0] > 0 || gapLeft[0] > 0));
    checkVal("A.ovr",  8'(ovrA),  8'(ovr[0]));
    checkVal("B.kb",   8'(kbB),   8'(pulseLeft[1] > 0 ? cur[1] : 4'b0));
    checkVal("B.busy", 8'(busyB), 8'(pulseLeft[1] > 0 || gapLeft[1] > 0));
    checkVal("B.ovr",  8'(ovrB),  8'(ovr[1]));
    rxValid = 1'b0; ovrClr = 1'b0; rstN = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    pool = '{"w", "s", "a", "d", "W", "S", "A", "D", " ", 8'h0d, "x", 8'h00, 8'h71};

    // Reset held for three clocks, then quiet outputs.
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("rst.kb", 8'(kbA), 8'h0);
    checkVal("rst.busy", 8'(busyA), 8'h0);
    checkVal("rst.ovr", 8'(ovrA), 8'h0);
    idle(3);
    checkVal("idle.kb", 8'(kbA), 8'h0);

    // Upper-case 'W': one-clock pulse, busy for two clocks.
    cycle(1'b1, "W", 1'b0, 1'b1);
    checkVal("w.kb", 8'(kbA), 8'h1);
    checkVal("w.busy1", 8'(busyA), 8'h1);
    idle(1);
    checkVal("w.gap", 8'(kbA), 8'h0);
    checkVal("w.busy2", 8'(busyA), 8'h1);
    idle(1);
    checkVal("w.busy3", 8'(busyA), 8'h0);
    idle(6);

    // Space then 'd' back to back: both delivered with a gap between.
    cycle(1'b1, " ", 1'b0, 1'b1);
    checkVal("sp.kb", 8'(kbA), 8'h8);
    cycle(1'b1, "d", 1'b0, 1'b1);
    checkVal("sp.gap", 8'(kbA), 8'h0);
    idle(1);
    checkVal("d.kb", 8'(kbA), 8'h4);
    idle(1);
    checkVal("d.gap", 8'(kbA), 8'h0);
    checkVal("d.ovr", 8'(ovrA), 8'h0);
    idle(8);

    // Four keys on consecutive clocks: 'w' is overwritten by 'd' while pending.
    cycle(1'b1, "a", 1'b0, 1'b1);
    checkVal("a.kb", 8'(kbA), 8'h3);
    cycle(1'b1, "s", 1'b0, 1'b1);
    cycle(1'b1, "w", 1'b0, 1'b1);
    checkVal("s.kb", 8'(kbA), 8'h2);
    checkVal("s.ovr", 8'(ovrA), 8'h0);
    cycle(1'b1, "d", 1'b0, 1'b1);
    checkVal("ovr.set", 8'(ovrA), 8'h1);
    idle(1);
    checkVal("ovr.d", 8'(kbA), 8'h4);
    idle(4);
    checkVal("ovr.sticky", 8'(ovrA), 8'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    checkVal("ovr.clr", 8'(ovrA), 8'h0);
    idle(8);

    // Unmapped bytes are ignored.
    cycle(1'b1, "x", 1'b0, 1'b1);
    cycle(1'b1, 8'h00, 1'b0, 1'b1);
    checkVal("x.kb", 8'(kbA), 8'h0);
    checkVal("x.busy", 8'(busyA), 8'h0);
    checkVal("x.ovr", 8'(ovrA), 8'h0);

    // Reset during the second EMIT clock of a four-clock pulse.
    cycle(1'b1, "s", 1'b0, 1'b1);
    checkVal("r6.kb1", 8'(kbB), 8'h2);
    idle(1);
    checkVal("r6.kb2", 8'(kbB), 8'h2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("r6.kbrst", 8'(kbB), 8'h0);
    checkVal("r6.busyrst", 8'(busyB), 8'h0);
    idle(6);
    checkVal("r6.after", 8'(kbB), 8'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 12)],
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 199) != 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
